// File: rtl/pipe_pkg.sv
// Shared types and default widths for the generic inter-stage pipeline registers.
// Holds the handshake stage state encoding and the ID/EX payload layouts.
package pipe_pkg;

    localparam int PIPE_DATA_W = 128;
    localparam int PIPE_CTRL_W = 16;
    localparam int PIPE_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    // ID/EX control bundle, 16 bits wide
    typedef struct packed {
        logic       reg_we;
        logic       mem_we;
        logic       mem_re;
        logic       alu_src;
        logic [1:0] wb_sel;
        logic [4:0] alu_op;
        logic [4:0] rd;
    } idex_ctrl_t;

    // ID/EX data bundle, 128 bits wide
    typedef struct packed {
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [26:0] pc_plus4;
        logic [4:0]  shamt;
    } idex_data_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared by rst.
// One cycle from inc to updated count; never wraps.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready, flush and bubble zeroing; 1-cycle latency, 1 beat/cycle.
// SKID=1 adds a skid entry so in_ready is registered; SKID=0 passes out_ready back combinationally.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q, in_ready_d;
    logic              in_fire;
    logic              out_fire;

    assign out_valid = (state_q != ST_EMPTY);
    // Without a skid entry FULL is unreachable: ONE only accepts when it also drains.
    assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_data  = main_data_q;
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d     = ST_ONE;
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end else if (in_fire) begin
                    state_d     = ST_FULL;
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_d     = ST_ONE;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                    skid_data_d = '0;
                    skid_ctrl_d = '0;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Flush drops everything, including a beat the upstream saw accepted; out_data keeps its last value.
        if (flush) begin
            state_d     = ST_EMPTY;
            main_data_d = main_data_q;
            main_ctrl_d = '0;
            skid_data_d = '0;
            skid_ctrl_d = '0;
        end

        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (out_valid && !out_ready),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance, each checked every cycle
// against a capacity-limited FIFO model, with directed scenarios followed by random traffic.
module tb_pipe_stage_reg;

    localparam int DW      = 128;
    localparam int CW      = 16;
    localparam int NW      = 4;
    localparam int CNT_MAX = 15;

    logic clk = 1'b0;
    logic rst;

    logic          flush     [2];
    logic          in_valid  [2];
    logic          in_ready  [2];
    logic [DW-1:0] in_data   [2];
    logic [CW-1:0] in_ctrl   [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic [DW-1:0] out_data  [2];
    logic [CW-1:0] out_ctrl  [2];
    logic [NW-1:0] stall_cnt [2];

    // Reference model: FIFO contents, last head shown, stall count, registered ready (skid only)
    logic [DW-1:0] m_d    [2][2];
    logic [CW-1:0] m_c    [2][2];
    int            m_sz   [2];
    logic [DW-1:0] m_last [2];
    int            m_cnt  [2];
    logic          m_rdy  [2];
    logic          acc    [2];

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) u_skid (
        .clk(clk), .rst(rst), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_ctrl(in_ctrl[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_ctrl(out_ctrl[0]),
        .stall_cnt(stall_cnt[0])
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) u_noskid (
        .clk(clk), .rst(rst), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_ctrl(in_ctrl[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_ctrl(out_ctrl[1]),
        .stall_cnt(stall_cnt[1])
    );

    task automatic chk(input int k, input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, expv);
        end
    endtask

    task automatic drv(input int k, input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl);
        in_valid[k]  = v;
        in_data[k]   = d;
        in_ctrl[k]   = c;
        out_ready[k] = ordy;
        flush[k]     = fl;
    endtask

    // Advance the model over the coming edge, then compare every output 1 time unit after it.
    task automatic tick();
        logic ir, inf, outf;
        for (int k = 0; k < 2; k++) begin
            ir     = (k == 0) ? m_rdy[k] : ((m_sz[k] == 0) || out_ready[k]);
            inf    = in_valid[k] && ir;
            outf   = (m_sz[k] > 0) && out_ready[k];
            acc[k] = inf && !rst;
            if (rst) begin
                m_sz[k]   = 0;
                m_last[k] = '0;
                m_cnt[k]  = 0;
            end else begin
                if ((m_sz[k] > 0) && !out_ready[k] && (m_cnt[k] < CNT_MAX)) m_cnt[k]++;
                if (flush[k]) begin
                    m_sz[k] = 0;
                end else begin
                    if (outf) begin
                        m_d[k][0] = m_d[k][1];
                        m_c[k][0] = m_c[k][1];
                        m_sz[k]--;
                    end
                    if (inf) begin
                        m_d[k][m_sz[k]] = in_data[k];
                        m_c[k][m_sz[k]] = in_ctrl[k];
                        m_sz[k]++;
                    end
                    if (m_sz[k] > 0) m_last[k] = m_d[k][0];
                end
            end
            m_rdy[k] = (m_sz[k] < 2);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk(k, "out_valid", out_valid[k], m_sz[k] > 0);
            chk(k, "out_data", out_data[k], (m_sz[k] > 0) ? m_d[k][0] : m_last[k]);
            chk(k, "out_ctrl", out_ctrl[k], (m_sz[k] > 0) ? m_c[k][0] : '0);
            chk(k, "in_ready", in_ready[k], (k == 0) ? m_rdy[k] : ((m_sz[k] == 0) || out_ready[k]));
            chk(k, "stall_cnt", stall_cnt[k], m_cnt[k]);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_sz[k]   = 0;
            m_last[k] = '0;
            m_cnt[k]  = 0;
            m_rdy[k]  = 1'b1;
            acc[k]    = 1'b0;
        end

        // Reset held two cycles with a beat offered
        rst = 1'b1;
        drv(0, 1'b1, 128'hdead, 16'h3F, 1'b1, 1'b0);
        drv(1, 1'b1, 128'hbeef, 16'h3F, 1'b1, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        drv(0, 1'b0, '0, '0, 1'b1, 1'b0);
        drv(1, 1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        chk(0, "rst_out_valid", out_valid[0], 1'b0);
        chk(0, "rst_out_ctrl", out_ctrl[0], '0);
        chk(0, "rst_stall_cnt", stall_cnt[0], '0);
        chk(0, "rst_in_ready", in_ready[0], 1'b1);

        // Back-to-back streaming 1..8
        for (int i = 1; i <= 8; i++) begin
            drv(0, 1'b1, DW'(i), CW'(i), 1'b1, 1'b0);
            tick();
            chk(0, "stream_data", out_data[0], DW'(i));
            chk(0, "stream_ready", in_ready[0], 1'b1);
        end
        drv(0, 1'b0, '0, '0, 1'b1, 1'b0);
        tick();

        // Skid fill: A, B accepted under stall, C held until space frees
        drv(0, 1'b1, 128'hA, 16'h1, 1'b0, 1'b0);
        tick();
        drv(0, 1'b1, 128'hB, 16'h2, 1'b0, 1'b0);
        tick();
        drv(0, 1'b1, 128'hC, 16'h3, 1'b0, 1'b0);
        tick();
        chk(0, "full_in_ready", in_ready[0], 1'b0);
        tick();
        chk(0, "skid_stall_cnt", stall_cnt[0], 4'd3);
        chk(0, "full_head", out_data[0], 128'hA);
        out_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (acc[0]) in_valid[0] = 1'b0;
        end
        chk(0, "drain_empty", out_valid[0], 1'b0);
        chk(0, "drain_last", out_data[0], 128'hC);

        // Flush while FULL with D offered
        drv(0, 1'b1, 128'hE, 16'h5, 1'b0, 1'b0);
        tick();
        drv(0, 1'b1, 128'hF, 16'h6, 1'b0, 1'b0);
        tick();
        drv(0, 1'b1, 128'hD, 16'h3F, 1'b0, 1'b1);
        tick();
        chk(0, "flush_valid", out_valid[0], 1'b0);
        chk(0, "flush_ctrl", out_ctrl[0], '0);
        chk(0, "flush_ready", in_ready[0], 1'b1);
        drv(0, 1'b0, '0, '0, 1'b1, 1'b0);
        repeat (3) tick();

        // Flush in ONE with simultaneous in_fire and out_fire
        drv(0, 1'b1, 128'h6, 16'h7, 1'b1, 1'b0);
        tick();
        drv(0, 1'b1, 128'hD, 16'h3F, 1'b1, 1'b1);
        tick();
        chk(0, "flush_drop_valid", out_valid[0], 1'b0);
        drv(0, 1'b0, '0, 16'h3F, 1'b1, 1'b0);
        repeat (2) tick();

        // Stall counter saturation
        drv(0, 1'b1, 128'h55, 16'h9, 1'b0, 1'b0);
        tick();
        drv(0, 1'b0, '0, '0, 1'b0, 1'b0);
        repeat (20) tick();
        chk(0, "sat_cnt", stall_cnt[0], 4'd15);
        tick();
        chk(0, "sat_hold", stall_cnt[0], 4'd15);
        out_ready[0] = 1'b1;
        tick();

        // SKID=0: combinational ready, stall/release ordering, bubble ctrl
        drv(1, 1'b1, 128'h11, 16'h1, 1'b1, 1'b0);
        tick();
        drv(1, 1'b1, 128'h22, 16'h2, 1'b0, 1'b0);
        #1;
        chk(1, "comb_ready", in_ready[1], 1'b0);
        tick();
        tick();
        chk(1, "stall_head", out_data[1], 128'h11);
        out_ready[1] = 1'b1;
        tick();
        chk(1, "release_next", out_data[1], 128'h22);
        drv(1, 1'b0, '0, 16'h3F, 1'b1, 1'b0);
        tick();
        chk(1, "bubble_ctrl", out_ctrl[1], '0);
        tick();
        chk(1, "bubble_ctrl2", out_ctrl[1], '0);

        // Random traffic on both instances with occasional flush and reset
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (!(in_valid[k] && !acc[k])) begin
                    in_valid[k] = ($urandom_range(3) != 0);
                    in_data[k]  = {$urandom, $urandom, $urandom, $urandom};
                    in_ctrl[k]  = CW'($urandom);
                end
                out_ready[k] = ($urandom_range(2) != 0);
                flush[k]     = ($urandom_range(31) == 0);
            end
            rst = ($urandom_range(199) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
